axil_mem_slave: RTL and testbench

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

---
 rtl/axil_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_axil_mem_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed on-chip memory.
// Each committed in-range write is also reported on a one-cycle mem_w strobe.
module axil_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_ARESETN,
    input  logic [ADDR_W-1:0]   AXI_AWADDR,
    input  logic                AXI_AWVALID,
    output logic                AXI_AWREADY,
    input  logic [DATA_W-1:0]   AXI_WDATA,
    input  logic [DATA_W/8-1:0] AXI_WSTRB,
    input  logic                AXI_WVALID,
    output logic                AXI_WREADY,
    output logic [1:0]          AXI_BRESP,
    output logic                AXI_BVALID,
    input  logic                AXI_BREADY,
    input  logic [ADDR_W-1:0]   AXI_ARADDR,
    input  logic                AXI_ARVALID,
    output logic                AXI_ARREADY,
    output logic [DATA_W-1:0]   AXI_RDATA,
    output logic [1:0]          AXI_RRESP,
    output logic                AXI_RVALID,
    input  logic                AXI_RREADY,
    output logic                axi_mem_w,
    output logic [ADDR_W-1:0]   axi_mem_addr,
    output logic [DATA_W-1:0]   axi_mem_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    // In range when no address bit above the word index is set.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> (OFF_W + IDX_W)) == {ADDR_W{1'b0}};
    endfunction

    logic                aw_full_r, w_full_r;
    logic [ADDR_W-1:0]   aw_addr_r;
    logic [DATA_W-1:0]   w_data_r;
    logic [STRB_W-1:0]   w_strb_r;
    logic                awready_r, wready_r, arready_r;
    logic                bvalid_r, rvalid_r;
    logic [1:0]          bresp_r, rresp_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                mem_w_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_data_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                aw_accept_s, w_accept_s, ar_accept_s, commit_s;
    logic                aw_in_range_s, ar_in_range_s;
    logic [IDX_W-1:0]    aw_idx_s, ar_idx_s;
    logic [DATA_W-1:0]   merged_s;

    assign aw_accept_s   = AXI_AWVALID && awready_r;
    assign w_accept_s    = AXI_WVALID && wready_r;
    assign ar_accept_s   = AXI_ARVALID && arready_r;
    assign commit_s      = aw_full_r && w_full_r && !bvalid_r;
    assign aw_in_range_s = in_range(aw_addr_r);
    assign ar_in_range_s = in_range(AXI_ARADDR);
    assign aw_idx_s      = aw_addr_r[OFF_W +: IDX_W];
    assign ar_idx_s      = AXI_ARADDR[OFF_W +: IDX_W];

    // Byte-merge buffered write data over the currently stored word.
    always_comb begin
        merged_s = mem_r[aw_idx_s];
        for (int b = 0; b < STRB_W; b++) begin
            merged_s[8*b +: 8] = w_strb_r[b] ? w_data_r[8*b +: 8] : mem_r[aw_idx_s][8*b +: 8];
        end
    end

    // Write channel: AW/W buffers, commit, B response and mem_w report.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            aw_full_r  <= 1'b0;
            aw_addr_r  <= {ADDR_W{1'b0}};
            w_full_r   <= 1'b0;
            w_data_r   <= {DATA_W{1'b0}};
            w_strb_r   <= {STRB_W{1'b0}};
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            mem_w_r    <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_data_r <= {DATA_W{1'b0}};
        end else begin
            if (commit_s) begin
                aw_full_r <= 1'b0;
            end else if (aw_accept_s) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= AXI_AWADDR;
            end
            if (commit_s) begin
                w_full_r <= 1'b0;
            end else if (w_accept_s) begin
                w_full_r <= 1'b1;
                w_data_r <= AXI_WDATA;
                w_strb_r <= AXI_WSTRB;
            end
            // Ready mirrors the buffer's next occupancy so it stays registered.
            awready_r <= commit_s || !(aw_full_r || aw_accept_s);
            wready_r  <= commit_s || !(w_full_r || w_accept_s);
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= aw_in_range_s ? 2'b00 : 2'b10;
            end else if (bvalid_r && AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
            mem_w_r <= commit_s && aw_in_range_s;
            if (commit_s && aw_in_range_s) begin
                mem_addr_r <= aw_addr_r;
                mem_data_r <= merged_s;
            end
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge AXI_ACLK) begin
        if (commit_s && aw_in_range_s) begin
            mem_r[aw_idx_s] <= merged_s;
        end
    end

    // Read channel; the array read sees pre-commit data on a same-cycle write.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            if (ar_accept_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= ar_in_range_s ? mem_r[ar_idx_s] : {DATA_W{1'b0}};
                rresp_r  <= ar_in_range_s ? 2'b00 : 2'b10;
            end else if (rvalid_r && AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
            arready_r <= !(ar_accept_s || (rvalid_r && !AXI_RREADY));
        end
    end

    assign AXI_AWREADY  = awready_r;
    assign AXI_WREADY   = wready_r;
    assign AXI_BVALID   = bvalid_r;
    assign AXI_BRESP    = bresp_r;
    assign AXI_ARREADY  = arready_r;
    assign AXI_RVALID   = rvalid_r;
    assign AXI_RDATA    = rdata_r;
    assign AXI_RRESP    = rresp_r;
    assign axi_mem_w    = mem_w_r;
    assign axi_mem_addr = mem_addr_r;
    assign axi_mem_data = mem_data_r;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Scoreboard bench for axil_mem_slave: expected B/R/mem_w events are queued
// as stimulus is issued and retired by a negedge monitor.
module tb_axil_mem_slave;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid, mem_w;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, mem_addr, mem_data;

    axil_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .axi_mem_w(mem_w), .axi_mem_addr(mem_addr), .axi_mem_data(mem_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mem_w_cnt = 0;
    int c0;
    logic prev_mem_w = 1'b0;
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [63:0] exp_m [$];
    logic [31:0] model_mem [DEPTH];
    logic [33:0] re;
    logic [63:0] me;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Retire scoreboard entries on completed handshakes and mem_w pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check_val("b_extra", 64'd1, 64'd0);
                else check_val("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) check_val("r_extra", 64'd1, 64'd0);
                else begin
                    re = exp_r.pop_front();
                    check_val("rdata", {32'd0, rdata}, {32'd0, re[31:0]});
                    check_val("rresp", {62'd0, rresp}, {62'd0, re[33:32]});
                end
            end
            if (mem_w) begin
                mem_w_cnt++;
                check_val("mem_w_width", {63'd0, prev_mem_w}, 64'd0);
                if (exp_m.size() == 0) check_val("mem_w_extra", 64'd1, 64'd0);
                else begin
                    me = exp_m.pop_front();
                    check_val("mem_addr", {32'd0, mem_addr}, {32'd0, me[63:32]});
                    check_val("mem_data", {32'd0, mem_data}, {32'd0, me[31:0]});
                end
            end
        end
        prev_mem_w <= mem_w;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (awready) begin
                @(posedge clk); #1; awvalid = 1'b0;
                return;
            end
        end
        check_val("aw_timeout", 64'd0, 64'd1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wready) begin
                @(posedge clk); #1; wvalid = 1'b0;
                return;
            end
        end
        check_val("w_timeout", 64'd0, 64'd1);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk); #1; arvalid = 1'b0;
                return;
            end
        end
        check_val("ar_timeout", 64'd0, 64'd1);
        arvalid = 1'b0;
    endtask

    task automatic prep_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        if (a < 32'(DEPTH * 4)) begin
            m = model_mem[a[9:2]];
            for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            model_mem[a[9:2]] = m;
            exp_b.push_back(2'b00);
            exp_m.push_back({a, m});
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        prep_write(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic read_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_r.push_back({r, d});
        send_ar(a);
    endtask

    task automatic read_model(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) read_exp(a, model_mem[a[9:2]], 2'b00);
        else read_exp(a, 32'h0, 2'b10);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_b.size() == 0 && exp_r.size() == 0 && exp_m.size() == 0 && !bvalid && !rvalid)
                return;
        end
        check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        tick(3);
        check_val("rst_awready", {63'd0, awready}, 64'd0);
        check_val("rst_wready",  {63'd0, wready},  64'd0);
        check_val("rst_arready", {63'd0, arready}, 64'd0);
        check_val("rst_bvalid",  {63'd0, bvalid},  64'd0);
        check_val("rst_rvalid",  {63'd0, rvalid},  64'd0);
        check_val("rst_mem_w",   {63'd0, mem_w},   64'd0);
        check_val("rst_rdata",   {32'd0, rdata},   64'd0);
        rst_n = 1'b1;
        tick(1);
        check_val("rel_awready", {63'd0, awready}, 64'd1);
        check_val("rel_wready",  {63'd0, wready},  64'd1);
        check_val("rel_arready", {63'd0, arready}, 64'd1);

        // Simultaneous AW/W, then readback; then a zero-strobe write.
        write(32'h10, 32'hDEADBEEF, 4'hF);
        wait_done();
        read_exp(32'h10, 32'hDEADBEEF, 2'b00);
        wait_done();
        write(32'h10, 32'hFFFFFFFF, 4'h0);
        wait_done();
        read_exp(32'h10, 32'hDEADBEEF, 2'b00);
        wait_done();

        // W leads AW by three cycles.
        c0 = mem_w_cnt;
        prep_write(32'h20, 32'hCAFEF00D, 4'hF);
        send_w(32'hCAFEF00D, 4'hF);
        tick(3);
        check_val("w_lead_wready", {63'd0, wready}, 64'd0);
        check_val("w_lead_bvalid", {63'd0, bvalid}, 64'd0);
        check_val("w_lead_no_commit", 64'(mem_w_cnt), 64'(c0));
        send_aw(32'h20);
        wait_done();
        check_val("w_lead_one_commit", 64'(mem_w_cnt), 64'(c0 + 1));
        read_exp(32'h20, 32'hCAFEF00D, 2'b00);
        wait_done();

        // Partial strobe merge.
        write(32'h30, 32'h11223344, 4'hF);
        wait_done();
        write(32'h30, 32'hAABBCCDD, 4'h5);
        wait_done();
        read_exp(32'h30, 32'h11BB33DD, 2'b00);
        wait_done();

        // B back-pressure with a second pair buffered behind it.
        bready = 1'b0;
        c0 = mem_w_cnt;
        write(32'h40, 32'h40404040, 4'hF);
        for (int i = 0; i < 20 && !bvalid; i++) tick(1);
        write(32'h44, 32'h44444444, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_val("bp_bvalid",  {63'd0, bvalid},  64'd1);
            check_val("bp_bresp",   {62'd0, bresp},   64'd0);
            check_val("bp_awready", {63'd0, awready}, 64'd0);
            check_val("bp_wready",  {63'd0, wready},  64'd0);
            check_val("bp_commits", 64'(mem_w_cnt), 64'(c0 + 1));
        end
        bready = 1'b1;
        wait_done();
        check_val("bp_commits_end", 64'(mem_w_cnt), 64'(c0 + 2));
        read_model(32'h40);
        wait_done();
        read_model(32'h44);
        wait_done();

        // Out-of-range write and read; word 0 aliases must stay untouched.
        write(32'h0, 32'h0BADF00D, 4'hF);
        wait_done();
        c0 = mem_w_cnt;
        write(32'h400, 32'h12345678, 4'hF);
        wait_done();
        check_val("oor_no_mem_w", 64'(mem_w_cnt), 64'(c0));
        read_exp(32'h400, 32'h0, 2'b10);
        wait_done();
        read_exp(32'h0, 32'h0BADF00D, 2'b00);
        wait_done();

        // AR accepted in the same cycle as a commit to the same word.
        write(32'h50, 32'h01010101, 4'hF);
        wait_done();
        exp_r.push_back({2'b00, 32'h01010101});
        prep_write(32'h50, 32'h5A5A5A5A, 4'hF);
        send_w(32'h5A5A5A5A, 4'hF);
        awaddr = 32'h50; awvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; araddr = 32'h50; arvalid = 1'b1;
        tick(1);
        arvalid = 1'b0;
        wait_done();
        read_model(32'h50);
        wait_done();

        // Concurrent read/write traffic with random strobes.
        for (int i = 0; i < 16; i++) write(32'h100 + 32'(i * 4), $urandom, 4'hF);
        wait_done();
        for (int i = 0; i < 12; i++) begin
            int w, r;
            logic [31:0] ra;
            w = $urandom_range(0, 15);
            r = (w + 1 + $urandom_range(0, 14)) % 16;
            ra = (i % 4 == 3) ? 32'h800 + 32'(r * 4) : 32'h100 + 32'(r * 4);
            fork
                write(32'h100 + 32'(w * 4), $urandom, 4'($urandom_range(0, 15)));
                read_model(ra);
            join
            wait_done();
        end

        // Reset while a read response is stalled.
        rready = 1'b0;
        send_ar(32'h10);
        for (int i = 0; i < 20 && !rvalid; i++) tick(1);
        tick(1);
        check_val("stall_rvalid", {63'd0, rvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_rvalid",  {63'd0, rvalid},  64'd0);
        check_val("arst_arready", {63'd0, arready}, 64'd0);
        check_val("arst_rdata",   {32'd0, rdata},   64'd0);
        tick(2);
        rst_n = 1'b1;
        rready = 1'b1;
        tick(1);
        check_val("arst_rel_arready", {63'd0, arready}, 64'd1);
        write(32'h60, 32'h600DCAFE, 4'hF);
        wait_done();
        read_exp(32'h60, 32'h600DCAFE, 2'b00);
        wait_done();

        check_val("exp_b_left", 64'(exp_b.size()), 64'd0);
        check_val("exp_r_left", 64'(exp_r.size()), 64'd0);
        check_val("exp_m_left", 64'(exp_m.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
